// File: rtl/optflow_pkg.sv
// Shared definitions for the optical-flow front end.
// Holds the default frame geometry, coordinate port widths and the
// sequencer state type used by gradient_frame_sequencer.
package optflow_pkg;

    localparam int DEF_WIDTH        = 320;
    localparam int DEF_HEIGHT       = 240;
    localparam int DEF_PIXEL_WIDTH  = 8;
    localparam int DEF_DRAIN_CYCLES = 8;

    // Coordinate ports are fixed width so downstream blocks do not
    // depend on the frame geometry parameters.
    localparam int X_BITS = 10;
    localparam int Y_BITS = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order position counter.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       return to (0,0), address 0
//   enable      advance one pixel in raster order
//   x, y, addr  current position and linear address y*WIDTH+x
//   last        current position is the final pixel of the frame
module raster_counter
    import optflow_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    output logic [X_BITS-1:0] x,
    output logic [Y_BITS-1:0] y,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic end_of_row;

    assign end_of_row = (x == X_BITS'(WIDTH - 1));
    assign last       = end_of_row && (y == Y_BITS'(HEIGHT - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clear || (enable && last)) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (enable) begin
            addr <= addr + ADDR_W'(1);
            if (end_of_row) begin
                x <= '0;
                y <= y + Y_BITS'(1);
            end else begin
                x <= x + X_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/gradient_frame_sequencer.sv
// Frame pass sequencer for the gradient datapath.
// Walks the current and previous frame buffers in raster order, forwards
// each pixel pair with its coordinates, waits for the gradient pipeline
// to drain, then pulses done together with frame_swap.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start, abort, stall            control (start sampled only when idle)
//   mem_rd_en, mem_rd_addr         shared read port to both frame buffers
//   mem_curr_data, mem_prev_data   read data, valid one cycle after the read
//   pixel_curr/prev/valid/x/y_out  pixel stream to the gradient datapath
//   grad_valid                     result strobe counted into grad_count
//   busy, done, frame_swap         pass status
module gradient_frame_sequencer
    import optflow_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int HEIGHT       = DEF_HEIGHT,
    parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic                                  stall,
    output logic                                  mem_rd_en,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]       mem_rd_addr,
    input  logic [PIXEL_WIDTH-1:0]                mem_curr_data,
    input  logic [PIXEL_WIDTH-1:0]                mem_prev_data,
    output logic [PIXEL_WIDTH-1:0]                pixel_curr,
    output logic [PIXEL_WIDTH-1:0]                pixel_prev,
    output logic                                  pixel_valid,
    output logic [X_BITS-1:0]                     pixel_x_out,
    output logic [Y_BITS-1:0]                     pixel_y_out,
    input  logic                                  grad_valid,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  frame_swap,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0]     grad_count
);

    localparam int ADDR_W  = $clog2(WIDTH * HEIGHT);
    localparam int CNT_W   = $clog2(WIDTH * HEIGHT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [CNT_W-1:0]   PIX_TOTAL  = CNT_W'(WIDTH * HEIGHT);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES);

    seq_state_t          state, state_d;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [X_BITS-1:0]   x;
    logic [Y_BITS-1:0]   y;
    logic [ADDR_W-1:0]   addr;
    logic                last;
    logic                accept;
    logic                issue;

    assign accept = (state == ST_IDLE) && start && !abort;

    // The read strobe is the STREAM phase qualified by the same-cycle stall
    // and abort, so a stall or abort withholds the read in the very cycle
    // it is raised. The address itself comes straight from a register.
    assign issue       = (state == ST_STREAM) && !stall && !abort;
    assign mem_rd_en   = issue;
    assign mem_rd_addr = addr;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (issue),
        .x      (x),
        .y      (y),
        .addr   (addr),
        .last   (last)
    );

    // NOTE: state_d is given its default before the case so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:   if (accept) state_d = ST_STREAM;
            ST_STREAM: begin
                if (abort)              state_d = ST_IDLE;
                else if (issue && last) state_d = ST_DRAIN;
            end
            // The first DRAIN cycle carries the final pixel_valid, so the
            // count of DRAIN_CYCLES starts after it.
            ST_DRAIN: begin
                if (abort)                         state_d = ST_IDLE;
                else if (drain_cnt == DRAIN_LAST)  state_d = ST_DONE;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            frame_swap <= 1'b0;
        end else begin
            state      <= state_d;
            drain_cnt  <= (state == ST_DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
            busy       <= (state_d == ST_STREAM) || (state_d == ST_DRAIN);
            done       <= (state_d == ST_DONE);
            frame_swap <= (state_d == ST_DONE);
        end
    end

    // Pixel qualifier and coordinates trail the read by one cycle; an
    // in-flight read always completes, whatever stall or abort do next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_valid <= 1'b0;
            pixel_x_out <= '0;
            pixel_y_out <= '0;
        end else begin
            pixel_valid <= issue;
            if (issue) begin
                pixel_x_out <= x;
                pixel_y_out <= y;
            end
        end
    end

    // Read data lands in the same cycle as pixel_valid; forward it
    // qualified so the outputs stay at zero whenever no pixel is present.
    assign pixel_curr = pixel_valid ? mem_curr_data : '0;
    assign pixel_prev = pixel_valid ? mem_prev_data : '0;

    // Result counter: cleared on an accepted start, held after the pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grad_count <= '0;
        end else if (accept) begin
            grad_count <= '0;
        end else if (grad_valid && busy && (grad_count != PIX_TOTAL)) begin
            grad_count <= grad_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gradient_frame_sequencer.sv
module tb_gradient_frame_sequencer;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int PW   = 8;
    localparam int DR   = 8;
    localparam int NPIX = W * H;
    localparam int MAXC = 160;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          stall;
    logic          mem_rd_en;
    logic [4:0]    mem_rd_addr;
    logic [PW-1:0] mem_curr_data;
    logic [PW-1:0] mem_prev_data;
    logic [PW-1:0] pixel_curr;
    logic [PW-1:0] pixel_prev;
    logic          pixel_valid;
    logic [9:0]    pixel_x_out;
    logic [8:0]    pixel_y_out;
    logic          grad_valid;
    logic          busy;
    logic          done;
    logic          frame_swap;
    logic [5:0]    grad_count;

    int total;
    int bad;

    gradient_frame_sequencer #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .PIXEL_WIDTH  (PW),
        .DRAIN_CYCLES (DR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .stall         (stall),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_curr_data (mem_curr_data),
        .mem_prev_data (mem_prev_data),
        .pixel_curr    (pixel_curr),
        .pixel_prev    (pixel_prev),
        .pixel_valid   (pixel_valid),
        .pixel_x_out   (pixel_x_out),
        .pixel_y_out   (pixel_y_out),
        .grad_valid    (grad_valid),
        .busy          (busy),
        .done          (done),
        .frame_swap    (frame_swap),
        .grad_count    (grad_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame buffer model: synchronous read, data valid the cycle after the
    // strobe; garbage is returned when no read was made.
    logic [PW-1:0] curr_mem [NPIX];
    logic [PW-1:0] prev_mem [NPIX];

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_curr_data <= curr_mem[mem_rd_addr];
            mem_prev_data <= prev_mem[mem_rd_addr];
        end else begin
            mem_curr_data <= PW'($urandom);
            mem_prev_data <= PW'($urandom);
        end
    end

    // Stimulus per cycle (cycle 0 = the start cycle).
    bit s_stall [MAXC];
    bit s_start [MAXC];
    bit s_gv    [MAXC];

    // Expected behaviour per cycle, derived from the frame-pass rules.
    bit e_rd    [MAXC];
    int e_addr  [MAXC];
    bit e_pv    [MAXC];
    int e_paddr [MAXC];
    bit e_busy  [MAXC];
    bit e_done  [MAXC];
    int e_cnt   [MAXC];

    task automatic clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            s_stall[c] = 1'b0;
            s_start[c] = 1'b0;
            s_gv[c]    = 1'b0;
        end
    endtask

    // Runs one pass starting at cycle 0 and checks every output each cycle.
    // Entry and exit are 1 time unit after a rising edge.
    task automatic run_frame(input string tag, input int abort_at);
        int issued, last, stop, ncyc;
        bit aborted;
        for (int i = 0; i < NPIX; i++) begin
            curr_mem[i] = PW'($urandom);
            prev_mem[i] = PW'($urandom);
        end
        for (int c = 0; c < MAXC; c++) begin
            e_rd[c] = 0; e_addr[c] = 0; e_pv[c] = 0; e_paddr[c] = 0;
            e_busy[c] = 0; e_done[c] = 0; e_cnt[c] = 0;
        end
        // Pixels go out one per unstalled cycle from cycle 1; the pass ends
        // with the last pixel_valid, DR drain cycles and one done cycle.
        issued = 0; last = -1; stop = -1; aborted = 0;
        for (int c = 1; c < MAXC - 4 && stop < 0; c++) begin
            if (c == abort_at) begin
                e_busy[c] = 1; aborted = 1; stop = c;
            end else if (last < 0) begin
                e_busy[c] = 1;
                if (!s_stall[c]) begin
                    e_rd[c] = 1; e_addr[c] = issued;
                    e_pv[c+1] = 1; e_paddr[c+1] = issued;
                    issued++;
                    if (issued == NPIX) last = c;
                end
            end else if (c <= last + DR + 1) begin
                e_busy[c] = 1;
            end else begin
                e_done[c] = 1; stop = c;
            end
        end
        ncyc = aborted ? stop + 4 : stop + 3;
        // Extra start pulses are only applied while a pass is in progress.
        for (int c = stop + 1; c < MAXC; c++) s_start[c] = 0;
        e_cnt[1] = 0;
        for (int c = 1; c < ncyc; c++) begin
            e_cnt[c+1] = e_cnt[c] + ((s_gv[c] && e_busy[c]) ? 1 : 0);
            if (e_cnt[c+1] > NPIX) e_cnt[c+1] = NPIX;
        end

        for (int c = 0; c < ncyc; c++) begin
            start      = (c == 0) ? 1'b1 : s_start[c];
            stall      = s_stall[c];
            abort      = (c == abort_at);
            grad_valid = s_gv[c];
            @(negedge clk);
            total++;
            if (mem_rd_en !== e_rd[c]) begin
                bad++;
                $display("FAIL %s rd_en c=%0d got=%0b exp=%0b", tag, c, mem_rd_en, e_rd[c]);
            end
            if (e_rd[c]) begin
                total++;
                if (mem_rd_addr !== 5'(e_addr[c])) begin
                    bad++;
                    $display("FAIL %s rd_addr c=%0d got=%0d exp=%0d", tag, c, mem_rd_addr, e_addr[c]);
                end
            end
            total++;
            if (pixel_valid !== e_pv[c]) begin
                bad++;
                $display("FAIL %s pixel_valid c=%0d got=%0b exp=%0b", tag, c, pixel_valid, e_pv[c]);
            end
            if (e_pv[c]) begin
                total += 4;
                if (pixel_x_out !== 10'(e_paddr[c] % W)) begin
                    bad++;
                    $display("FAIL %s pixel_x c=%0d got=%0d exp=%0d", tag, c, pixel_x_out, e_paddr[c] % W);
                end
                if (pixel_y_out !== 9'(e_paddr[c] / W)) begin
                    bad++;
                    $display("FAIL %s pixel_y c=%0d got=%0d exp=%0d", tag, c, pixel_y_out, e_paddr[c] / W);
                end
                if (pixel_curr !== curr_mem[e_paddr[c]]) begin
                    bad++;
                    $display("FAIL %s pixel_curr c=%0d got=%0h exp=%0h", tag, c, pixel_curr, curr_mem[e_paddr[c]]);
                end
                if (pixel_prev !== prev_mem[e_paddr[c]]) begin
                    bad++;
                    $display("FAIL %s pixel_prev c=%0d got=%0h exp=%0h", tag, c, pixel_prev, prev_mem[e_paddr[c]]);
                end
            end
            total += 3;
            if (busy !== e_busy[c]) begin
                bad++;
                $display("FAIL %s busy c=%0d got=%0b exp=%0b", tag, c, busy, e_busy[c]);
            end
            if (done !== e_done[c]) begin
                bad++;
                $display("FAIL %s done c=%0d got=%0b exp=%0b", tag, c, done, e_done[c]);
            end
            if (frame_swap !== e_done[c]) begin
                bad++;
                $display("FAIL %s frame_swap c=%0d got=%0b exp=%0b", tag, c, frame_swap, e_done[c]);
            end
            if (c >= 1) begin
                total++;
                if (grad_count !== 6'(e_cnt[c])) begin
                    bad++;
                    $display("FAIL %s grad_count c=%0d got=%0d exp=%0d", tag, c, grad_count, e_cnt[c]);
                end
            end
            @(posedge clk); #1;
        end
        start = 0; stall = 0; abort = 0; grad_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 0; abort = 0; stall = 0; grad_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({mem_rd_en, pixel_valid, busy, done, frame_swap} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=00000", {mem_rd_en, pixel_valid, busy, done, frame_swap});
        end
        total++;
        if ({mem_rd_addr, pixel_x_out, pixel_y_out, grad_count} !== '0) begin
            bad++;
            $display("FAIL reset_counters addr=%0d x=%0d y=%0d cnt=%0d exp=0", mem_rd_addr, pixel_x_out, pixel_y_out, grad_count);
        end
        total++;
        if ({pixel_curr, pixel_prev} !== '0) begin
            bad++;
            $display("FAIL reset_pixels got=%h exp=0", {pixel_curr, pixel_prev});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_frame();
        clear_stim();
        run_frame("basic", -1);
    endtask

    task automatic test_stall_fixed();
        clear_stim();
        for (int c = 5; c <= 7; c++) s_stall[c] = 1;
        run_frame("stall_5_7", -1);
    endtask

    task automatic test_abort_stream();
        clear_stim();
        run_frame("abort_stream", 10);
    endtask

    task automatic test_abort_drain();
        clear_stim();
        run_frame("abort_drain", NPIX + int'($urandom_range(1, DR + 1)));
    endtask

    task automatic test_abort_priority();
        start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if ({mem_rd_en, busy, pixel_valid} !== 3'b0) begin
                bad++;
                $display("FAIL abort_prio c=%0d got=%b exp=000", c, {mem_rd_en, busy, pixel_valid});
            end
        end
    endtask

    task automatic test_reset_midframe();
        start = 1;
        for (int c = 0; c < 20; c++) begin
            grad_valid = (c > 0);
            @(posedge clk); #1;
            start = 0;
        end
        grad_valid = 0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({mem_rd_en, pixel_valid, busy, done, frame_swap} !== 5'b0) begin
            bad++;
            $display("FAIL midreset_ctrl got=%b exp=00000", {mem_rd_en, pixel_valid, busy, done, frame_swap});
        end
        total++;
        if ({mem_rd_addr, pixel_x_out, pixel_y_out, grad_count, pixel_curr, pixel_prev} !== '0) begin
            bad++;
            $display("FAIL midreset_data addr=%0d x=%0d y=%0d cnt=%0d exp=0", mem_rd_addr, pixel_x_out, pixel_y_out, grad_count);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        clear_stim();
        run_frame("after_reset", -1);
    endtask

    task automatic test_grad_count();
        clear_stim();
        for (int c = 1; c <= 32; c++) s_gv[c] = 1;
        run_frame("grad_32", -1);
        total++;
        if (grad_count !== 6'd32) begin
            bad++;
            $display("FAIL grad_32_final got=%0d exp=32", grad_count);
        end
        clear_stim();
        for (int c = 1; c <= 40; c++) s_gv[c] = 1;
        run_frame("grad_sat", -1);
        total++;
        if (grad_count !== 6'd32) begin
            bad++;
            $display("FAIL grad_sat_final got=%0d exp=32", grad_count);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            clear_stim();
            for (int c = 1; c < MAXC; c++) begin
                s_stall[c] = (c <= 60) && ($urandom_range(0, 3) == 0);
                s_gv[c]    = $urandom_range(0, 1) == 1;
                s_start[c] = $urandom_range(0, 4) == 0;
            end
            run_frame("random", -1);
        end
    endtask

    // Consecutive passes with start held through busy and the done cycle.
    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            clear_stim();
            for (int c = 1; c < MAXC; c++) s_start[c] = 1;
            run_frame("back_to_back", -1);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_frame();
        test_stall_fixed();
        test_abort_stream();
        test_abort_drain();
        test_abort_priority();
        test_reset_midframe();
        test_grad_count();
        test_random_frames();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gradient_frame_sequencer.md
GRADIENT_FRAME_SEQUENCER -- requirements
Module: gradient_frame_sequencer

Interface
REQ-001 SHALL have parameters: WIDTH 320 (frame columns); HEIGHT 240 (frame rows); PIXEL_WIDTH 8 (pixel bits); DRAIN_CYCLES 8 (post-stream wait for gradient pipeline).
REQ-002 SHALL use one clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  request one frame pass; sampled only in IDLE.
REQ-006 abort  in  1  synchronous abort; returns to IDLE without done.
REQ-007 stall  in  1  pause issuing memory reads while high.
REQ-008 mem_rd_en  out  1  read strobe shared by current and previous frame buffers.
REQ-009 mem_rd_addr  out  $clog2(WIDTH*HEIGHT)  raster address, y*WIDTH+x.
REQ-010 mem_curr_data, mem_prev_data  in  PIXEL_WIDTH each  read data, valid 1 cycle after mem_rd_en.
REQ-011 pixel_curr, pixel_prev  out  PIXEL_WIDTH each  pixels to gradient datapath.
REQ-012 pixel_valid  out  1  pixel qualifier; pixel_x_out 10, pixel_y_out 9  out  coordinates of issued pixel.
REQ-013 grad_valid  in  1  result strobe from gradient datapath.
REQ-014 busy  out  1; done  out  1 (one-cycle pulse); frame_swap  out  1 (one-cycle pulse with done); grad_count  out  $clog2(WIDTH*HEIGHT+1).

Function
REQ-015 FSM states SHALL be IDLE, STREAM, DRAIN, DONE; all outputs registered.
REQ-016 IDLE->STREAM on start and not abort; x,y,addr cleared to 0, grad_count cleared.
REQ-017 In STREAM, each cycle with stall low SHALL assert mem_rd_en with current addr, then advance x; x wraps WIDTH-1->0 incrementing y; addr increments by 1.
REQ-018 mem_rd_en SHALL first assert the cycle after start is sampled (latency 1).
REQ-019 pixel_valid, pixel_curr/prev, pixel_x_out/y_out SHALL be mem_rd_en, memory data and issued coordinates delayed exactly 1 cycle; stall never suppresses an in-flight pixel.
REQ-020 After issuing (WIDTH-1, HEIGHT-1), STREAM->DRAIN; no further mem_rd_en.
REQ-021 DRAIN SHALL count DRAIN_CYCLES cycles beginning the cycle after the last pixel_valid, independent of stall, then go to DONE.
REQ-022 DONE SHALL last one cycle asserting done and frame_swap, then IDLE.
REQ-023 busy SHALL be high in STREAM and DRAIN only.
REQ-024 grad_count SHALL increment on grad_valid while busy, saturate at WIDTH*HEIGHT, hold after done until next accepted start.
REQ-025 start while not IDLE SHALL be ignored; start in DONE cycle ignored.
REQ-026 abort in STREAM/DRAIN SHALL go to IDLE next cycle, drop mem_rd_en that cycle, no done/frame_swap; abort has priority over start and stall.
REQ-027 An in-flight read at abort SHALL still produce its pixel_valid cycle.

Reset
REQ-028 On rst_n low all outputs SHALL be 0, state IDLE, counters 0, asynchronously; reset mid-frame discards progress with no done.
REQ-029 First start after reset release SHALL behave as from power-up.

Structure
REQ-030 Shared package optflow_pkg SHALL hold the state enum type and default WIDTH/HEIGHT/PIXEL_WIDTH constants.
REQ-031 One sub-module raster_counter (x, y, addr, last flag, enable) is natural; remainder inline.

Verification (WIDTH=8, HEIGHT=4, DRAIN_CYCLES=8)
REQ-032 start at cycle 0, no stall -> mem_rd_en cycles 1-32 addr 0-31, pixel_valid cycles 2-33, done+frame_swap cycle 42 only.
REQ-033 stall high cycles 5-7 -> addr 4 issued cycle 5 not; addr 4 at cycle 8, done at cycle 45, pixel order unchanged.
REQ-034 row wrap -> address 8 emitted with pixel_x_out 0, pixel_y_out 1; last pixel (7,3) addr 31.
REQ-035 abort cycle 10 -> mem_rd_en low from cycle 10, one trailing pixel_valid cycle 10, busy low cycle 11, no done.
REQ-036 rst_n low cycle 20 mid-STREAM -> all outputs 0 immediately; start after release restarts at addr 0.
REQ-037 start pulses during busy and in DONE cycle ignored; 32 grad_valid pulses -> grad_count 32, 40 pulses saturate at 32.
